// File: rtl/bsg_manycore_reset_sequencer.sv
// Power-on / host-requested reset sequencer for manycore domains: hold, staggered
// per-domain release, wait for tag programming, then retimed reset_done and host release.
module bsg_manycore_reset_sequencer #(
  parameter int num_domains_p    = 4,
  parameter int hold_cycles_p    = 16,
  parameter int stagger_cycles_p = 3,
  parameter int done_delay_p     = 3,
  parameter int timeout_width_p  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     sw_reset_v_i,
  input  logic [num_domains_p-1:0] tag_done_i,
  output logic [num_domains_p-1:0] domain_reset_o,
  output logic                     host_reset_o,
  output logic                     reset_done_o,
  output logic                     timeout_o
);

  // One shared phase counter serves HOLD, RELEASE and DELAY; it never needs to
  // reach the largest of the three periods, only that value minus one.
  localparam int hs_max_lp      = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p : stagger_cycles_p;
  localparam int count_max_lp   = (hs_max_lp > done_delay_p) ? hs_max_lp : done_delay_p;
  localparam int count_width_lp = (count_max_lp > 1) ? $clog2(count_max_lp) : 1;
  localparam int idx_width_lp   = (num_domains_p > 1) ? $clog2(num_domains_p) : 1;

  localparam logic [count_width_lp-1:0] hold_last_lp    = count_width_lp'(hold_cycles_p - 1);
  localparam logic [count_width_lp-1:0] stagger_last_lp = count_width_lp'(stagger_cycles_p - 1);
  localparam logic [count_width_lp-1:0] delay_last_lp   =
    count_width_lp'((done_delay_p > 0) ? done_delay_p - 1 : 0);
  localparam logic [idx_width_lp-1:0]   last_domain_lp  = idx_width_lp'(num_domains_p - 1);

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT_TAG,
    DELAY,
    DONE
  } state_e;

  state_e                     state_r, state_n;
  logic [count_width_lp-1:0]  count_r, count_n;
  logic [idx_width_lp-1:0]    idx_r, idx_n;
  logic [timeout_width_p-1:0] tcount_r, tcount_n;
  logic [num_domains_p-1:0]   domain_n;
  logic                       host_n, done_n, timeout_n;
  logic                       all_tagged;

  assign all_tagged = &tag_done_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r        <= HOLD;
      count_r        <= '0;
      idx_r          <= '0;
      tcount_r       <= '0;
      domain_reset_o <= '1;
      host_reset_o   <= 1'b1;
      reset_done_o   <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      state_r        <= state_n;
      count_r        <= count_n;
      idx_r          <= idx_n;
      tcount_r       <= tcount_n;
      domain_reset_o <= domain_n;
      host_reset_o   <= host_n;
      reset_done_o   <= done_n;
      timeout_o      <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state_r;
    count_n   = count_r;
    idx_n     = idx_r;
    tcount_n  = tcount_r;
    domain_n  = domain_reset_o;
    timeout_n = timeout_o;

    if (sw_reset_v_i) begin
      state_n   = HOLD;
      count_n   = '0;
      idx_n     = '0;
      tcount_n  = '0;
      domain_n  = '1;
      timeout_n = 1'b0;
    end else begin
      unique case (state_r)
        HOLD: begin
          if (count_r == hold_last_lp) begin
            domain_n[0] = 1'b0;
            count_n     = '0;
            if (num_domains_p == 1) begin
              state_n  = WAIT_TAG;
              tcount_n = '0;
            end else begin
              state_n = RELEASE;
              idx_n   = idx_width_lp'(1);
            end
          end else begin
            count_n = count_r + count_width_lp'(1);
          end
        end
        RELEASE: begin
          if (count_r == stagger_last_lp) begin
            domain_n[idx_r] = 1'b0;
            count_n         = '0;
            if (idx_r == last_domain_lp) begin
              state_n  = WAIT_TAG;
              tcount_n = '0;
            end else begin
              idx_n = idx_r + idx_width_lp'(1);
            end
          end else begin
            count_n = count_r + count_width_lp'(1);
          end
        end
        WAIT_TAG: begin
          // Timeout only flags a slow tag master; completion still proceeds.
          if (tcount_r == '1) begin
            timeout_n = 1'b1;
          end else begin
            tcount_n = tcount_r + timeout_width_p'(1);
          end
          if (all_tagged) begin
            count_n = '0;
            state_n = (done_delay_p == 0) ? DONE : DELAY;
          end
        end
        DELAY: begin
          if (!all_tagged) begin
            state_n  = WAIT_TAG;
            count_n  = '0;
            tcount_n = '0;
          end else if (count_r == delay_last_lp) begin
            state_n = DONE;
          end else begin
            count_n = count_r + count_width_lp'(1);
          end
        end
        DONE: begin
          if (!all_tagged) begin
            state_n  = WAIT_TAG;
            count_n  = '0;
            tcount_n = '0;
          end
        end
        default: begin
          state_n = HOLD;
        end
      endcase
    end

    done_n = (state_n == DONE);
    host_n = !done_n;
  end

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// Randomized scoreboard bench: a run-length reference model predicts each cycle's outputs
// for a 4-domain and a 1-domain/zero-delay sequencer driven by shared reset inputs.
module tb_bsg_manycore_reset_sequencer;

  localparam int h_lp = 16;
  localparam int s_lp = 3;
  localparam int w_lp = 8;

  typedef struct {
    int seq;
    int run;
    int wrun;
    bit tmo;
  } model_t;

  typedef struct {
    int         cyc;
    logic [3:0] dom;
    logic       host;
    logic       done;
    logic       tmo;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_reset_v = 1'b0;
  logic [3:0] tag_done = 4'h0;

  logic [3:0] dom0;
  logic       host0, done0, tmo0;
  logic [0:0] dom1;
  logic       host1, done1, tmo1;

  int     cycle_no = 0;
  int     vectors = 0;
  int     miscompares = 0;
  model_t m0, m1;
  exp_t   q0[$];
  exp_t   q1[$];

  bsg_manycore_reset_sequencer #(
    .num_domains_p(4), .hold_cycles_p(h_lp), .stagger_cycles_p(s_lp),
    .done_delay_p(3), .timeout_width_p(w_lp)
  ) dut (
    .clk_i(clk), .reset_i(reset), .sw_reset_v_i(sw_reset_v), .tag_done_i(tag_done),
    .domain_reset_o(dom0), .host_reset_o(host0), .reset_done_o(done0), .timeout_o(tmo0)
  );

  bsg_manycore_reset_sequencer #(
    .num_domains_p(1), .hold_cycles_p(h_lp), .stagger_cycles_p(s_lp),
    .done_delay_p(0), .timeout_width_p(w_lp)
  ) dut1 (
    .clk_i(clk), .reset_i(reset), .sw_reset_v_i(sw_reset_v), .tag_done_i(tag_done[0:0]),
    .domain_reset_o(dom1), .host_reset_o(host1), .reset_done_o(done1), .timeout_o(tmo1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  // Reference: seq is the cycle index since restart; run counts consecutive all-tagged
  // cycles inside the tag window; wrun counts consecutive cycles spent waiting for tags.
  function automatic model_t model_step(input model_t m, input int n, input bit restart,
                                        input bit all_ones);
    model_t r;
    int     wst;
    bit     inreg;
    if (restart) begin
      r.seq = 0; r.run = 0; r.wrun = 0; r.tmo = 1'b0;
      return r;
    end
    wst    = h_lp + (n - 1) * s_lp;
    inreg  = (m.seq >= wst);
    r.wrun = (inreg && m.run == 0) ? m.wrun + 1 : 0;
    r.tmo  = m.tmo || (r.wrun >= (1 << w_lp));
    r.run  = (inreg && all_ones) ? m.run + 1 : 0;
    r.seq  = m.seq + 1;
    return r;
  endfunction

  function automatic exp_t model_expect(input model_t m, input int n, input int d, input int cyc);
    exp_t e;
    e.cyc = cyc;
    e.dom = 4'h0;
    for (int k = 0; k < n; k++) e.dom[k] = (m.seq < h_lp + k * s_lp);
    e.done = (m.run >= d + 1);
    e.host = !e.done;
    e.tmo  = m.tmo;
    return e;
  endfunction

  task automatic compare(input string name, input int cyc, input logic [3:0] act,
                         input logic [3:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, req);
    end
  endtask

  task automatic check_output(input string inst, input exp_t e, input logic [3:0] dom,
                              input logic host, input logic done, input logic tmo);
    compare({inst, ".domain_reset"}, e.cyc, dom, e.dom);
    compare({inst, ".host_reset"}, e.cyc, {3'b0, host}, {3'b0, e.host});
    compare({inst, ".reset_done"}, e.cyc, {3'b0, done}, {3'b0, e.done});
    compare({inst, ".timeout"}, e.cyc, {3'b0, tmo}, {3'b0, e.tmo});
  endtask

  task automatic apply_stimulus(input bit rst, input bit sw, input logic [3:0] tag);
    @(posedge clk);
    #1;
    reset      = rst;
    sw_reset_v = sw;
    tag_done   = tag;
    m0 = model_step(m0, 4, rst || sw, &tag);
    q0.push_back(model_expect(m0, 4, 3, cycle_no + 1));
    m1 = model_step(m1, 1, rst || sw, tag[0]);
    q1.push_back(model_expect(m1, 1, 0, cycle_no + 1));
  endtask

  function automatic logic [3:0] rand_tag();
    return ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
  endfunction

  // Monitor: compares each expectation against the DUT during the cycle it targets.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0 && q0[0].cyc < cycle_no) begin
      e = q0.pop_front();
      compare("dut4.stale", cycle_no, 4'(cycle_no - e.cyc), 4'h0);
    end else if (q0.size() > 0 && q0[0].cyc == cycle_no) begin
      e = q0.pop_front();
      check_output("dut4", e, dom0, host0, done0, tmo0);
    end
    if (q1.size() > 0 && q1[0].cyc < cycle_no) begin
      e = q1.pop_front();
      compare("dut1.stale", cycle_no, 4'(cycle_no - e.cyc), 4'h0);
    end else if (q1.size() > 0 && q1[0].cyc == cycle_no) begin
      e = q1.pop_front();
      check_output("dut1", e, {3'b0, dom1}, host1, done1, tmo1);
    end
  end

  initial begin
    m0 = '{0, 0, 0, 1'b0};
    m1 = '{0, 0, 0, 1'b0};

    repeat (3) apply_stimulus(1'b1, 1'b0, 4'hF);
    repeat (40) apply_stimulus(1'b0, 1'b0, 4'hF);

    // Host replay, then tag dropouts around DONE.
    apply_stimulus(1'b0, 1'b1, 4'hF);
    repeat (80) apply_stimulus(1'b0, 1'b0, ($urandom_range(0, 9) == 0) ? 4'hD : 4'hF);

    // One slow tag bit.
    apply_stimulus(1'b1, 1'b0, 4'hF);
    repeat ($urandom_range(60, 100)) apply_stimulus(1'b0, 1'b0, 4'hB);
    repeat (20) apply_stimulus(1'b0, 1'b0, 4'hF);

    // No tags long enough to saturate the timeout, then late completion.
    apply_stimulus(1'b1, 1'b0, 4'hF);
    repeat (300) apply_stimulus(1'b0, 1'b0, 4'h0);
    repeat (15) apply_stimulus(1'b0, 1'b0, 4'hF);

    // Reset abandoned mid-release, and sw_reset held for several cycles.
    apply_stimulus(1'b1, 1'b0, 4'hF);
    repeat ($urandom_range(5, 30)) apply_stimulus(1'b0, 1'b0, 4'hF);
    repeat (2) apply_stimulus(1'b1, 1'b1, 4'hF);
    repeat (45) apply_stimulus(1'b0, 1'b0, 4'hF);
    repeat (3) apply_stimulus(1'b0, 1'b1, 4'hF);
    repeat (45) apply_stimulus(1'b0, 1'b0, 4'hF);

    for (int i = 0; i < 2000; i++) begin
      apply_stimulus($urandom_range(0, 299) == 0, $urandom_range(0, 149) == 0, rand_tag());
    end

    repeat (3) apply_stimulus(1'b0, 1'b0, 4'hF);
    repeat (3) @(posedge clk);
    compare("queue_drain", cycle_no, 4'(q0.size() + q1.size()), 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
